// File: rtl/mux_seq_pkg.sv
// Shared encodings and constants for the 4-step pattern mux sequencer.
package mux_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NSTEPS = 4;
    localparam int SEL_W  = 2;

    // Pattern lookup for a given step index.
    function automatic logic [3:0] pick_pattern(
        input logic [SEL_W-1:0] s,
        input logic [3:0]       p0,
        input logic [3:0]       p1,
        input logic [3:0]       p2,
        input logic [3:0]       p3
    );
        logic [3:0] r;
        case (s)
            2'd0:    r = p0;
            2'd1:    r = p1;
            2'd2:    r = p2;
            default: r = p3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mux_seq_presc.sv
// NP-bit dwell prescaler with synchronous clear and count enable; tick marks the all-ones count.
module mux_seq_presc #(
    parameter int NP = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    logic [NP-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + NP'(1);
        end
    end

    assign o_tick = &r_cnt;

endmodule

// File: rtl/mux_seq_ctrl.sv
// Start/stop sequencer driving a 4-input pattern mux onto registered LED outputs.
// Optional pause input enabled by defining MUX_SEQ_CTRL_PAUSE_EN.
module mux_seq_ctrl
    import mux_seq_pkg::*;
#(
    parameter int         NP = 22,
    parameter logic [3:0] V0 = 4'h3,
    parameter logic [3:0] V1 = 4'hC,
    parameter logic [3:0] V2 = 4'h5,
    parameter logic [3:0] V3 = 4'hA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
`ifdef MUX_SEQ_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic [SEL_W-1:0] sel,
    output logic [3:0]       data,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: start/stop are level-sampled every cycle; start is only
    // accepted in IDLE with stop low, stop wins over everything in RUN.

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [3:0]       r_data;
    logic             r_busy;
    logic             r_done;
    logic             r_loop;

    state_t           w_state_nx;
    logic [SEL_W-1:0] w_sel_nx;
    logic [3:0]       w_data_nx;
    logic             w_busy_nx;
    logic             w_done_nx;
    logic             w_loop_nx;
    logic             w_tick;
    logic             w_pause;
    logic             w_presc_clr;
    logic             w_presc_en;

`ifdef MUX_SEQ_CTRL_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Holding the prescaler cleared outside RUN makes every pass start at count 0.
    assign w_presc_clr = (r_state != ST_RUN);
    assign w_presc_en  = (r_state == ST_RUN) && !w_pause;

    mux_seq_presc #(
        .NP (NP)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_presc_clr),
        .i_en   (w_presc_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_loop_nx  = r_loop;
        case (r_state)
            ST_IDLE: begin
                w_sel_nx = '0;
                if (start && !stop) begin
                    w_state_nx = ST_RUN;
                    w_loop_nx  = loop;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nx = ST_IDLE;
                    w_sel_nx   = '0;
                end else if (w_tick && !w_pause) begin
                    if (r_sel != SEL_W'(NSTEPS - 1)) begin
                        w_sel_nx = r_sel + SEL_W'(1);
                    end else if (r_loop) begin
                        w_sel_nx = '0;
                    end else begin
                        w_state_nx = ST_DONE;
                        w_sel_nx   = '0;
                    end
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
                w_sel_nx   = '0;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_sel_nx   = '0;
            end
        endcase
        // Outputs are registered from the next state so they line up with it.
        w_busy_nx = (w_state_nx == ST_RUN);
        w_done_nx = (w_state_nx == ST_DONE);
        w_data_nx = w_busy_nx ? pick_pattern(w_sel_nx, V0, V1, V2, V3) : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= '0;
            r_data <= 4'h0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_loop <= 1'b0;
        end else begin
            r_sel  <= w_sel_nx;
            r_data <= w_data_nx;
            r_busy <= w_busy_nx;
            r_done <= w_done_nx;
            r_loop <= w_loop_nx;
        end
    end

    assign sel       = r_sel;
    assign data      = r_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
